// File: rtl/blink_pkg.sv
// Shared blink definitions: mode encoding, default cycle constants, helpers.
package blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_FAST = 2'd2,
    MODE_ON   = 2'd3
  } mode_t;

  localparam int unsigned DEF_DEB_CYC  = 20000;
  localparam int unsigned DEF_SLOW_CYC = 500000;
  localparam int unsigned DEF_FAST_CYC = 100000;
  localparam int unsigned DEF_LONG_CYC = 1000000;

  // Larger of two cycle constants.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Mode sequence OFF -> SLOW -> FAST -> ON -> OFF.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:  return MODE_SLOW;
      MODE_SLOW: return MODE_FAST;
      MODE_FAST: return MODE_ON;
      default:   return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton synchronizer and debouncer: debounced level plus one-cycle press pulse.
// After reset the button must be seen released for DEB_CYC cycles before any
// press can be reported, so a button held through reset is ignored.
module btn_debounce
  import blink_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEF_DEB_CYC,
  parameter int unsigned CNT_W   = cnt_width(DEF_DEB_CYC)
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic btn_n,
  output logic deb_level,
  output logic press
);

  logic [1:0]       sync_q;
  logic             deb_q;
  logic             armed_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sync_c;
  logic             hit_c;

  assign sync_c = sync_q[1];
  assign hit_c  = (cnt_q == CNT_W'(DEB_CYC - 1));

  // Synchronize, arm on a stable release, then debounce and flag the 1->0 edge.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      deb_q   <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n};
      press_q <= 1'b0;
      if (!armed_q) begin
        if (sync_c) begin
          if (hit_c) begin
            armed_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end else if (sync_c != deb_q) begin
        if (hit_c) begin
          deb_q   <= sync_c;
          cnt_q   <= '0;
          press_q <= ~sync_c;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign deb_level = deb_q;
  assign press     = press_q;

endmodule

// File: rtl/btn_blink_ctrl.sv
// Button-driven blink mode controller: cycles OFF/SLOW/FAST/ON on each press and
// emits toggle ticks for the LED toggler in SLOW and FAST.
// Optional feature macro: BTN_LONGPRESS_EN (long hold forces OFF).
module btn_blink_ctrl
  import blink_pkg::*;
#(
  parameter int unsigned DEB_CYC  = DEF_DEB_CYC,
  parameter int unsigned SLOW_CYC = DEF_SLOW_CYC,
  parameter int unsigned FAST_CYC = DEF_FAST_CYC,
  parameter int unsigned LONG_CYC = DEF_LONG_CYC
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       btn_n,
  output logic [1:0] mode,
  output logic       tick,
  output logic       hold_on
);

  localparam int unsigned CNT_W =
    cnt_width(max2(max2(DEB_CYC, SLOW_CYC), max2(FAST_CYC, LONG_CYC)));

  logic             deb_level;
  logic             press;
  logic             press_ev_c;
  logic             long_fire_c;
  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_q, tick_d;
  logic             hold_on_q;
  logic [CNT_W-1:0] tick_last_c;

  btn_debounce #(
    .DEB_CYC (DEB_CYC),
    .CNT_W   (CNT_W)
  ) u_debounce (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .btn_n     (btn_n),
    .deb_level (deb_level),
    .press     (press)
  );

`ifdef BTN_LONGPRESS_EN
  logic [CNT_W-1:0] long_cnt_q;
  logic             long_done_q;

  assign long_fire_c = !deb_level && !long_done_q &&
                       (long_cnt_q == CNT_W'(LONG_CYC - 1));
  assign press_ev_c  = press && !deb_level && !long_done_q;

  // Measure the debounced hold; fire once per hold, re-arm on release.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
    end else if (deb_level) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
    end else if (!long_done_q) begin
      if (long_fire_c) begin
        long_cnt_q  <= '0;
        long_done_q <= 1'b1;
      end else begin
        long_cnt_q <= long_cnt_q + CNT_W'(1);
      end
    end
  end
`else
  assign long_fire_c = 1'b0;
  assign press_ev_c  = press && !deb_level;
`endif

  assign tick_last_c = (mode_q == MODE_SLOW) ? CNT_W'(SLOW_CYC - 1) : CNT_W'(FAST_CYC - 1);

  // Mode, tick counter and output registers.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      mode_q     <= MODE_OFF;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      hold_on_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      hold_on_q  <= (mode_d == MODE_ON);
    end
  end

  // Next mode; tick counter restarts on any mode change and runs only in SLOW/FAST.
  always_comb begin
    mode_d     = mode_q;
    tick_cnt_d = '0;
    tick_d     = 1'b0;
    if (press_ev_c) begin
      mode_d = next_mode(mode_q);
    end
    if (long_fire_c) begin
      mode_d = MODE_OFF;
    end
    if (mode_d != mode_q) begin
      tick_cnt_d = '0;
      tick_d     = 1'b0;
    end else if ((mode_q == MODE_SLOW) || (mode_q == MODE_FAST)) begin
      if (tick_cnt_q == tick_last_c) begin
        tick_cnt_d = '0;
        tick_d     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mode    = mode_q;
  assign tick    = tick_q;
  assign hold_on = hold_on_q;

endmodule

// File: tb/tb_btn_blink_ctrl.sv
// Scoreboard bench for btn_blink_ctrl (DEB=4, SLOW=10, FAST=3, LONG=20).
// Stimulus pushes expected mode-change and tick events with their cycle numbers;
// a negedge monitor pops and compares whenever the DUT shows one.
module tb_btn_blink_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SLOW = 10;
  localparam int unsigned FAST = 3;
  localparam int unsigned LONG = 20;
  // Drive of btn_n low to visible mode change: 2 sync + DEB debounce + 1 register.
  localparam int PRESS_LAT = 7;

  typedef struct {
    bit         is_tick;
    logic [1:0] mode;
    int         cyc;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       btn_n;
  logic [1:0] mode;
  logic       tick;
  logic       hold_on;

  ev_t        exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [1:0] prev_mode = 2'd0;

  btn_blink_ctrl #(
    .DEB_CYC  (DEB),
    .SLOW_CYC (SLOW),
    .FAST_CYC (FAST),
    .LONG_CYC (LONG)
  ) dut (
    .CLK     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_n),
    .mode    (mode),
    .tick    (tick),
    .hold_on (hold_on)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input bit t, input logic [1:0] m, input int c);
    ev_t e;
    e.is_tick = t;
    e.mode    = m;
    e.cyc     = c;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare one observed event against the head of the scoreboard.
  task automatic check_ev(input bit t, input logic [1:0] m);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got tick=%0b mode=%0d at cycle %0d, none expected", t, m, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_tick !== t || e.mode !== m || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got tick=%0b mode=%0d cycle=%0d, expected tick=%0b mode=%0d cycle=%0d",
                 t, m, cyc, e.is_tick, e.mode, e.cyc);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One press (optionally preceded by 20 cycles of bounce); segment lasts s cycles
  // from the clean drive, so the next mode change is at d+s+PRESS_LAT.
  task automatic press(input bit bounce, input int s, input logic [1:0] m, input int n);
    int d;
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        btn_n = i[0];
        step(2);
      end
    end
    d = cyc;
    push_ev(1'b0, m, d + PRESS_LAT);
    if (n > 0) begin
      for (int t = d + PRESS_LAT + n; t < d + s + PRESS_LAT; t += n) push_ev(1'b1, m, t);
    end
    btn_n = 1'b0;
    step(8);
    btn_n = 1'b1;
    step(s - 8);
  endtask

  // Hold 30 cycles from FAST: ON after the press, then OFF after 20 debounced-low cycles if enabled.
  task automatic long_hold();
    int d;
    d = cyc;
    push_ev(1'b0, 2'd3, d + PRESS_LAT);
`ifdef BTN_LONGPRESS_EN
    push_ev(1'b0, 2'd0, d + PRESS_LAT - 1 + LONG);
`endif
    btn_n = 1'b0;
    step(30);
    btn_n = 1'b1;
    step(20);
  endtask

  // Monitor: invariants every cycle, scoreboard on mode changes and ticks.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (hold_on !== (mode == 2'd3)) begin
        errors++;
        $display("FAIL hold_on: got %0b with mode=%0d at cycle %0d", hold_on, mode, cyc);
      end
      checks++;
      if (tick === 1'b1 && (mode == 2'd0 || mode == 2'd3)) begin
        errors++;
        $display("FAIL tick_in_static_mode: tick=1 with mode=%0d at cycle %0d", mode, cyc);
      end
      if (mode !== prev_mode) check_ev(1'b0, mode);
      if (tick === 1'b1) check_ev(1'b1, mode);
      prev_mode = mode;
    end
  end

  initial begin
    rst_n = 1'b0;
    btn_n = 1'b0;
    step(3);
    @(negedge clk);
    check_val("reset_mode", mode, 2'd0);
    check_val("reset_tick", {1'b0, tick}, 2'd0);
    check_val("reset_hold_on", {1'b0, hold_on}, 2'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Button held through reset: nothing may happen until released.
    step(15);
    btn_n = 1'b1;
    step(10);

    press(1'b1, 40, 2'd1, SLOW);   // bounce then hold: single press into SLOW
    press(1'b0, 20, 2'd2, FAST);
    press(1'b0, 20, 2'd3, 0);
    press(1'b0, 20, 2'd0, 0);
    press(1'b0, 20, 2'd1, SLOW);
    press(1'b0, 20, 2'd2, FAST);
    long_hold();
    step(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_blink_ctrl.md
BTN_BLINK_CTRL -- requirements
Module: btn_blink_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYC, default 20000, stable cycles for the debounced button level to be accepted.
REQ-002 SHALL have parameter SLOW_CYC, default 500000, cycles between ticks in SLOW mode.
REQ-003 SHALL have parameter FAST_CYC, default 100000, cycles between ticks in FAST mode.
REQ-004 SHALL have parameter LONG_CYC, default 1000000, debounced-press duration treated as a long press (only with BTN_LONGPRESS_EN).
REQ-005 SHALL have port CLK, input, 1, the single system clock (1 MHz nominal).
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port btn_n, input, 1, raw asynchronous pushbutton, active-low.
REQ-008 SHALL have port mode, output, 2, current mode: 0 OFF, 1 SLOW, 2 FAST, 3 ON.
REQ-009 SHALL have port tick, output, 1, one-cycle toggle strobe for the downstream LED toggler.
REQ-010 SHALL have port hold_on, output, 1, high only in ON mode (LED forced lit).

Function
REQ-011 SHALL pass btn_n through a 2-flop synchronizer before any other use.
REQ-012 SHALL update the debounced level only after the synchronized input has differed from it for DEB_CYC consecutive cycles; any bounce restarts the count.
REQ-013 SHALL generate a press event in the single cycle the debounced level goes 1->0; release SHALL generate no event.
REQ-014 SHALL advance mode OFF->SLOW->FAST->ON->OFF on each press event, registered in the cycle after the event.
REQ-015 SHALL run a tick counter only in SLOW/FAST, counting 0..N-1 (N = SLOW_CYC or FAST_CYC) and asserting tick for one cycle when count = N-1, then wrapping to 0.
REQ-016 SHALL clear the tick counter on every mode change, with no tick in the change cycle; the first tick in the new mode comes N cycles later.
REQ-017 SHALL hold tick = 0 in OFF and ON.
REQ-018 SHALL size counters to the largest parameter value, with no overflow for any legal value >= 2.
REQ-019 SHALL ignore a press held longer than DEB_CYC beyond the single event (no auto-repeat).

Reset
REQ-020 SHALL, while rst_n = 0 at a CLK edge, set mode = OFF, tick = 0, hold_on = 0, all counters = 0, and debounced level = 1 (released).
REQ-021 SHALL abandon any in-progress debounce or tick count on reset; a button held through reset release SHALL produce no press until it is released and pressed again.

Configuration
REQ-022 SHALL, with BTN_LONGPRESS_EN defined, force mode to OFF when the debounced level stays low for LONG_CYC cycles, once per hold, suppressing any further advance until release.
REQ-023 SHALL, with BTN_LONGPRESS_EN undefined, omit the long-press counter entirely; holds behave as single presses.

Structure
REQ-024 SHALL place the mode encoding (OFF/SLOW/FAST/ON) and default cycle constants in shared package blink_pkg, used by this block and the LED toggler.
REQ-025 SHALL implement synchronizer plus debounce as sub-module btn_debounce (outputs debounced level and press pulse).

Verification (bench parameters: DEB_CYC=4, SLOW_CYC=10, FAST_CYC=3, LONG_CYC=20)
REQ-026 SHALL check reset: rst_n low 3 cycles with btn_n=0 -> mode=0, tick=0, hold_on=0; no press until btn_n goes high >=4 cycles and then low again.
REQ-027 SHALL check bounce: btn_n toggles every 2 cycles for 20 cycles, then held low -> exactly one press, mode 0->1.
REQ-028 SHALL check rates: in SLOW, ticks are exactly 10 cycles apart; after the next press (FAST), the first tick comes 3 cycles after the mode change, then every 3 cycles.
REQ-029 SHALL check wrap: 4 clean presses -> modes 1,2,3,0; hold_on=1 only in mode 3; tick never asserted in modes 0 or 3.
REQ-030 SHALL check long press with BTN_LONGPRESS_EN: in FAST, hold btn_n low 30 cycles -> mode 0 at 20 debounced-low cycles, no further change until release; without the macro, mode goes 2->3 only.
